// File: rtl/tmds_encoder.sv
// -----------------------------------------------------------------------------
// tmds_encoder
//
// Purpose
//   One channel of a DVI/HDMI TMDS 8b/10b encoder. It sits right after the VGA
//   timing generator and produces one DC-balanced 10-bit symbol per pixel clock
//   for the serializer. The blue instance carries {vsync,hsync} on c1/c0; the
//   red and green instances tie c1/c0 low.
//
//   Two register stages, fixed latency:
//     stage 1 : transition-minimised word q_m[8:0], de, {c1,c0}
//     stage 2 : tmds_out and the running disparity counter cnt
//   Inputs sampled at edge N are registered into tmds_out at edge N+1, so they
//   are on the output when edge N+2 samples it.
//
// Parameters
//   CTRL_RST  control code {c1,c0} whose symbol is driven during and after reset
//
// Ports
//   clk       in   1   pixel clock, the only clock
//   rst       in   1   synchronous, active-low reset
//   data_in   in   8   pixel component, used when de=1
//   de        in   1   1 = video period, 0 = control period
//   c0        in   1   control bit 0, used when de=0
//   c1        in   1   control bit 1, used when de=0
//   tmds_out  out  10  encoded symbol, bit 0 transmitted first
//   disp_dbg  out  5   (only with TMDS_DISP_DBG_EN) registered signed cnt
//
// Configuration
//   TMDS_DISP_DBG_EN : when defined, adds the disp_dbg port exposing the running
//                      disparity. Encoding is identical either way.
// -----------------------------------------------------------------------------
module tmds_encoder #(
  parameter logic [1:0] CTRL_RST = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              de,
  input  logic              c0,
  input  logic              c1,
  output logic [9:0]        tmds_out
`ifdef TMDS_DISP_DBG_EN
  ,
  output logic signed [4:0] disp_dbg
`endif
);

  // Control-period symbols, indexed by {c1,c0}.
  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [9:0] ctrl_symbol(input logic [1:0] code);
    logic [9:0] sym;
    case (code)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

  // Transition-minimising chain. XNOR is chosen when the byte is ones-heavy
  // (or exactly balanced with a 0 in bit 0); q_m[8]=1 marks the XOR path so
  // the receiver knows which chain to undo.
  function automatic logic [8:0] build_qm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: q_m, de and control code
  // ---------------------------------------------------------------------------
  logic [8:0] qm_d,   qm_q;
  logic       de1_d,  de1_q;
  logic [1:0] ctrl_d, ctrl_q;

  always_comb begin
    qm_d   = build_qm(data_in);
    de1_d  = de;
    ctrl_d = {c1, c0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      qm_q   <= '0;
      de1_q  <= 1'b0;
      // Holding the reset control code here keeps the reset symbol on the
      // output for the first cycle after reset is released.
      ctrl_q <= CTRL_RST;
    end else begin
      qm_q   <= qm_d;
      de1_q  <= de1_d;
      ctrl_q <= ctrl_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: DC balancing and output register
  // ---------------------------------------------------------------------------
  // cnt is 5-bit two's complement and never leaves [-10,+10]. The per-symbol
  // update is formed in 6 bits so intermediate terms cannot wrap, then
  // truncated back to 5 bits.
  logic [3:0]        n1q;
  logic signed [5:0] bal;        // ones minus zeros in q_m[7:0]
  logic signed [5:0] cnt_ext;
  logic signed [5:0] delta;
  logic signed [5:0] cnt_sum;
  logic              qm8;
  logic              cnt_pos;
  logic              cnt_neg;
  logic              bal_pos;
  logic              bal_neg;

  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d,  cnt_q;

  always_comb begin
    n1q     = popcount8(qm_q[7:0]);
    bal     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[4], cnt_q};
    qm8     = qm_q[8];
    cnt_neg = cnt_q[4];
    cnt_pos = !cnt_q[4] && (cnt_q != 5'sd0);
    bal_neg = bal[5];
    bal_pos = !bal[5] && (bal != 6'sd0);

    tmds_d  = ctrl_symbol(ctrl_q);
    delta   = 6'sd0;
    cnt_sum = 6'sd0;
    cnt_d   = 5'sd0;

    if (de1_q) begin
      if ((cnt_q == 5'sd0) || (bal == 6'sd0)) begin
        // No history to correct, or the word is already balanced: invert
        // only to keep q_m[8] and the inversion flag complementary.
        tmds_d = {~qm8, qm8, (qm8 ? qm_q[7:0] : ~qm_q[7:0])};
        delta  = qm8 ? bal : (6'sd0 - bal);
      end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
        // Word would push disparity further the same way: send it inverted.
        tmds_d = {1'b1, qm8, ~qm_q[7:0]};
        delta  = (qm8 ? 6'sd2 : 6'sd0) - bal;
      end else begin
        tmds_d = {1'b0, qm8, qm_q[7:0]};
        delta  = bal - (qm8 ? 6'sd0 : 6'sd2);
      end
      cnt_sum = cnt_ext + delta;
      cnt_d   = cnt_sum[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmds_q <= ctrl_symbol(CTRL_RST);
      cnt_q  <= 5'sd0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_out = tmds_q;

`ifdef TMDS_DISP_DBG_EN
  assign disp_dbg = cnt_q;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_encoder
//
// Self-checking bench for tmds_encoder: a directed vector table, a mid-burst
// reset sequence, then randomized traffic checked against an integer reference
// model, a symbol decoder and a running disparity tracker built from the
// emitted symbols.
// -----------------------------------------------------------------------------
module tb_tmds_encoder;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       de = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic [9:0] tmds_out;
`ifdef TMDS_DISP_DBG_EN
  logic signed [4:0] disp_dbg;
`endif

  always #5 clk = ~clk;

  tmds_encoder #(.CTRL_RST(2'b00)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .de       (de),
    .c0       (c0),
    .c1       (c1),
    .tmds_out (tmds_out)
`ifdef TMDS_DISP_DBG_EN
    ,
    .disp_dbg (disp_dbg)
`endif
  );

  // ---------------------------------------------------------------------------
  // Counters and constants
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [9:0] ctrl_tab [4];
  logic [9:0] sym00;

  // ---------------------------------------------------------------------------
  // Reference model (integer arithmetic on the encoding rules)
  // ---------------------------------------------------------------------------
  int m_cnt = 0;

  task automatic ref_model(input logic e, input logic [7:0] d,
                           input logic [1:0] c, output logic [9:0] sym);
    logic [8:0] q;
    int n1, n1q, n0q, q8;
    if (!e) begin
      m_cnt = 0;
      sym   = ctrl_tab[c];
    end else begin
      n1   = $countones(d);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
        if ((n1 > 4) || (n1 == 4 && d[0] == 1'b0)) q[i] = ~(q[i-1] ^ d[i]);
        else                                         q[i] = q[i-1] ^ d[i];
      end
      q[8] = ((n1 > 4) || (n1 == 4 && d[0] == 1'b0)) ? 1'b0 : 1'b1;
      n1q  = $countones(q[7:0]);
      n0q  = 8 - n1q;
      q8   = q[8] ? 1 : 0;
      if (m_cnt == 0 || n1q == n0q) begin
        sym   = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
        m_cnt = m_cnt + (q8 == 1 ? (n1q - n0q) : (n0q - n1q));
      end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
        sym   = {1'b1, q[8], ~q[7:0]};
        m_cnt = m_cnt + 2 * q8 + (n0q - n1q);
      end else begin
        sym   = {1'b0, q[8], q[7:0]};
        m_cnt = m_cnt - 2 * (1 - q8) + (n1q - n0q);
      end
    end
  endtask

  // Receiver-side decode of a data symbol back to the pixel byte.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [9:0] exp_q[$];
  logic       exp_de_q[$];
  int         exp_cnt_q[$];
  logic [7:0] exp_dat_q[$];
  int         run_disp = 0;

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_sym(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // One clock with model tracking. A reset cycle empties the pipeline model
  // and loads two reset symbols: one for this edge, one for the cleared stage 1.
  task automatic cycle(input logic r, input logic e, input logic [7:0] d,
                       input logic [1:0] c, input string tag);
    logic [9:0] sym, got, exp_sym;
    logic       exp_de;
    int         exp_cnt;
    logic [7:0] exp_dat;
    rst = r; de = e; data_in = d; c1 = c[1]; c0 = c[0];
    if (!r) begin
      exp_q.delete(); exp_de_q.delete(); exp_cnt_q.delete(); exp_dat_q.delete();
      m_cnt = 0;
      repeat (2) begin
        exp_q.push_back(sym00); exp_de_q.push_back(1'b0);
        exp_cnt_q.push_back(0); exp_dat_q.push_back(8'h00);
      end
    end else begin
      ref_model(e, d, c, sym);
      exp_q.push_back(sym); exp_de_q.push_back(e);
      exp_cnt_q.push_back(m_cnt); exp_dat_q.push_back(d);
    end
    @(posedge clk); #1;
    cyc++;
    got     = tmds_out;
    exp_sym = exp_q.pop_front();
    exp_de  = exp_de_q.pop_front();
    exp_cnt = exp_cnt_q.pop_front();
    exp_dat = exp_dat_q.pop_front();
    check_sym(tag, got, exp_sym);
    if (exp_de) begin
      run_disp = run_disp + 2 * $countones(got) - 10;
      check_int({tag, "_decode"}, int'(decode(got)), int'(exp_dat));
      check_int({tag, "_disp_track"}, run_disp, exp_cnt);
      check_int({tag, "_disp_bound"}, (run_disp >= -10 && run_disp <= 10) ? 1 : 0, 1);
    end else begin
      run_disp = 0;
    end
`ifdef TMDS_DISP_DBG_EN
    check_int({tag, "_disp_dbg"}, int'(disp_dbg), exp_cnt);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: each row's exp is tmds_out just after that row's edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [1:0] c_rand;
    logic       e_rand;
    logic [7:0] d_rand;
    int         mode;

    ctrl_tab[0] = 10'b1101010100;
    ctrl_tab[1] = 10'b0010101011;
    ctrl_tab[2] = 10'b0101010100;
    ctrl_tab[3] = 10'b1010101011;
    sym00       = ctrl_tab[0];

    // reset for 3 clocks, then control codes, zero bytes, 0xFF, cnt clearing
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 2'b00, 10'b1101010100};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 2'b00, 10'b1101010100};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 2'b00, 10'b1101010100};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 2'b00, 10'b1101010100};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 2'b01, 10'b1101010100};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 2'b10, 10'b0010101011};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 2'b11, 10'b0101010100};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 2'b00, 10'b1010101011};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 2'b00, 10'b0100000000};  // cnt -8
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 2'b00, 10'b1111111111};  // cnt +2
    vecs[10] = '{1'b1, 1'b0, 8'h00, 2'b00, 10'b0100000000};  // cnt -6
    vecs[11] = '{1'b1, 1'b1, 8'hFF, 2'b00, 10'b1101010100};  // cnt 0
    vecs[12] = '{1'b1, 1'b0, 8'h00, 2'b00, 10'b1000000000};  // cnt -8
    vecs[13] = '{1'b1, 1'b1, 8'h00, 2'b00, 10'b1101010100};  // cnt 0
    vecs[14] = '{1'b1, 1'b0, 8'h00, 2'b00, 10'b0100000000};  // fresh from cnt 0
    vecs[15] = '{1'b1, 1'b0, 8'h00, 2'b00, 10'b1101010100};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; de = vecs[i].de; data_in = vecs[i].data;
      c1 = vecs[i].c[1]; c0 = vecs[i].c[0];
      @(posedge clk); #1;
      cyc++;
      check_sym($sformatf("vec%0d", i), tmds_out, vecs[i].exp);
    end

    // Mid-burst reset: one low cycle discards both in-flight symbols.
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 2'b00, "rst_mid_pre");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 2'b00, "burst_a");
    cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 2'b00, "rst_mid_pulse");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 2'b00, "burst_b");

    // de toggling every cycle with extreme bytes
    for (int i = 0; i < 16; i++)
      cycle(1'b1, i[0], (i[1] ? 8'hFF : 8'h00), 2'(i[3:2]), "de_toggle");

    // Randomized traffic: alternating bursty and per-cycle-random de modes.
    e_rand = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      mode = (i / 500) % 2;
      if (mode == 0) begin
        if ($urandom_range(0, 9) == 0) e_rand = ~e_rand;
      end else begin
        e_rand = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 7))
        0:       d_rand = 8'h00;
        1:       d_rand = 8'hFF;
        2:       d_rand = 8'h0F;
        default: d_rand = 8'($urandom_range(0, 255));
      endcase
      c_rand = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1999) == 0) cycle(1'b0, e_rand, d_rand, c_rand, "rand_rst");
      else                              cycle(1'b1, e_rand, d_rand, c_rand, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
